ex_result_stage: RTL and testbench



---
 rtl/ex_result_if.sv | 33 +++
 rtl/ex_result_stage.sv | 116 +++++++++++
 tb/tb_ex_result_stage.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_result_if.sv
// Handshake and data bundle between the execute back end and the memory stage.
// The master side drives the execute inputs; the slave side is the result stage.
interface ex_result_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_out;
    logic              alu_co;
    logic              a_sign;
    logic              b_sign;
    logic [2:0]        set_op;
    logic [REG_W-1:0]  rd_in;
    logic              wr_en_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [REG_W-1:0]  out_rd;
    logic              out_wr_en;
    logic [2:0]        out_flags;

    modport master (
        output in_valid, alu_out, alu_co, a_sign, b_sign, set_op, rd_in, wr_en_in, flush, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wr_en, out_flags
    );

    modport slave (
        input  in_valid, alu_out, alu_co, a_sign, b_sign, set_op, rd_in, wr_en_in, flush, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wr_en, out_flags
    );
endinterface

// File: rtl/ex_result_stage.sv
// Execute back end: resolves set-condition ops, computes {Z,N,C} flags and
// registers the result into a 2-entry skid buffer toward the memory stage.
module ex_result_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic           clk,
    input  logic           rst,
    ex_result_if.slave     bus
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              wr_en;
        logic [2:0]        flags;
    } entry_t;

    localparam logic [2:0] OP_SEQ = 3'b001;
    localparam logic [2:0] OP_SLT = 3'b010;
    localparam logic [2:0] OP_SLE = 3'b011;
    localparam logic [2:0] OP_SCO = 3'b100;

    logic [1:0]        count_q, count_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic              push, pop;
    logic              alu_z, lt;
    logic [DATA_W-1:0] result;
    entry_t            new_entry;
    entry_t            head_entry;
    entry_t [1:0]      ent_all;

    // Signed compare from A-B: when signs differ the subtraction may overflow,
    // so the sign of A alone decides.
    always_comb begin
        alu_z  = (bus.alu_out == '0);
        lt     = (bus.a_sign ^ bus.b_sign) ? bus.a_sign : bus.alu_out[DATA_W-1];
        result = bus.alu_out;
        case (bus.set_op)
            OP_SEQ:  result = {{(DATA_W-1){1'b0}}, alu_z};
            OP_SLT:  result = {{(DATA_W-1){1'b0}}, lt};
            OP_SLE:  result = {{(DATA_W-1){1'b0}}, lt | alu_z};
            OP_SCO:  result = {{(DATA_W-1){1'b0}}, bus.alu_co};
            default: result = bus.alu_out;
        endcase
        new_entry.result = result;
        new_entry.rd     = bus.rd_in;
        new_entry.wr_en  = bus.wr_en_in;
        new_entry.flags  = {(result == '0), result[DATA_W-1], bus.alu_co};
    end

    // Ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (bus.flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        entry_t ent_q, ent_d;

        always_comb begin
            ent_d = ent_q;
            if (push && (tail_q == 1'(gi))) ent_d = new_entry;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) ent_q <= '0;
            else     ent_q <= ent_d;
        end

        assign ent_all[gi] = ent_q;
    end

    // Stale storage is masked so an empty buffer presents all-zero outputs.
    always_comb begin
        head_entry = '0;
        if (bus.out_valid) head_entry = ent_all[head_q];
    end

    assign bus.out_result = head_entry.result;
    assign bus.out_rd     = head_entry.rd;
    assign bus.out_wr_en  = head_entry.wr_en;
    assign bus.out_flags  = head_entry.flags;

endmodule

// File: tb/tb_ex_result_stage.sv
// Self-checking bench for ex_result_stage: directed scenarios plus randomized
// traffic against a queue-based reference model built from operand values.
module tb_ex_result_stage;
    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  rd;
        logic        wr_en;
        logic [2:0]  flags;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ex_result_if #(.DATA_W(16), .REG_W(3)) bus ();

    ex_result_stage #(.DATA_W(16), .REG_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Stimulus expressed as operands; the model derives expectations from them.
    logic [2:0]  stim_op;
    logic [15:0] stim_a, stim_b, stim_raw;
    logic        stim_co;
    logic [2:0]  stim_rd;
    logic        stim_we;
    ent_t        exp_q[$];

    function automatic ent_t exp_entry();
        ent_t e;
        logic [15:0] r;
        case (stim_op)
            3'd1:    r = (stim_a == stim_b) ? 16'd1 : 16'd0;
            3'd2:    r = ($signed(stim_a) <  $signed(stim_b)) ? 16'd1 : 16'd0;
            3'd3:    r = ($signed(stim_a) <= $signed(stim_b)) ? 16'd1 : 16'd0;
            3'd4:    r = {15'd0, stim_co};
            default: r = stim_raw;
        endcase
        e.result = r;
        e.rd     = stim_rd;
        e.wr_en  = stim_we;
        e.flags  = {(r == 16'd0), r[15], stim_co};
        return e;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] raw, input logic co,
                         input logic [2:0] rd, input logic we, input logic fl, input logic ordy);
        stim_op = op; stim_a = a; stim_b = b; stim_raw = raw;
        stim_co = co; stim_rd = rd; stim_we = we;
        bus.in_valid  = v;
        bus.set_op    = op;
        bus.alu_out   = (op >= 3'd1 && op <= 3'd3) ? (a - b) : raw;
        bus.alu_co    = co;
        bus.a_sign    = a[15];
        bus.b_sign    = b[15];
        bus.rd_in     = rd;
        bus.wr_en_in  = we;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    // Advance one clock and update the model; leaves time at posedge+1.
    task automatic tick();
        bit   do_push, do_pop, do_flush;
        ent_t e;
        do_flush = bus.flush;
        do_push  = bus.in_valid && (exp_q.size() < 2) && !do_flush;
        do_pop   = (exp_q.size() > 0) && bus.out_ready && !do_flush;
        e = exp_entry();
        @(posedge clk); #1;
        if (do_flush) exp_q.delete();
        else begin
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        drive(0, 3'd0, 16'd0, 16'd0, 16'd0, 0, 3'd0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_handshake out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.out_result, bus.out_rd, bus.out_wr_en, bus.out_flags} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs result=%h rd=%0d we=%b flags=%b required all 0",
                     bus.out_result, bus.out_rd, bus.out_wr_en, bus.out_flags);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_set_ops();
        logic [2:0]  ops   [5] = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [15:0] as    [5] = '{16'h7FFF, 16'h0001, 16'h0005, 16'h0000, 16'h0000};
        logic [15:0] bs    [5] = '{16'hFFFE, 16'h0002, 16'h0005, 16'h0000, 16'h0000};
        logic [15:0] raws  [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h8000};
        logic        cos   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] want_r[5] = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h8000};
        logic [2:0]  want_f[5] = '{3'b100, 3'b000, 3'b000, 3'b001, 3'b010};
        for (int i = 0; i < 5; i++) begin
            drive(1, ops[i], as[i], bs[i], raws[i], cos[i], 3'(i + 1), 1, 0, 1);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== want_r[i] || bus.out_flags !== want_f[i]) begin
                failures++;
                $display("FAIL set_op_case%0d valid=%b result=%h flags=%b required 1/%h/%b",
                         i, bus.out_valid, bus.out_result, bus.out_flags, want_r[i], want_f[i]);
            end
        end
        drive(0, 3'd0, 16'd0, 16'd0, 16'd0, 0, 3'd0, 0, 0, 1);
        tick();
    endtask

    task automatic test_backpressure();
        logic [15:0] vals[3] = '{16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 3; i++) begin
            drive(1, 3'd0, 16'd0, 16'd0, vals[i], 0, 3'(i + 4), 1, 0, 0);
            tick();
            if (i >= 1) begin
                checks++;
                if (bus.in_ready !== 1'b0 || bus.out_result !== 16'h1111) begin
                    failures++;
                    $display("FAIL backpressure_full%0d in_ready=%b head=%h required 0/1111",
                             i, bus.in_ready, bus.out_result);
                end
            end
        end
        drive(0, 3'd0, 16'd0, 16'd0, 16'd0, 0, 3'd0, 0, 0, 1);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h1111) begin
            failures++;
            $display("FAIL backpressure_head0 valid=%b result=%h required 1/1111", bus.out_valid, bus.out_result);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h2222 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_head1 valid=%b result=%h in_ready=%b required 1/2222/1",
                     bus.out_valid, bus.out_result, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_drain valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) begin
            drive(1, 3'd0, 16'd0, 16'd0, 16'($urandom), 0, 3'((i % 7) + 1), 1, 0, 1);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_rd !== 3'((i % 7) + 1) || bus.in_ready !== 1'b1) begin
                failures++;
                $display("FAIL streaming_cycle%0d valid=%b rd=%0d in_ready=%b required 1/%0d/1",
                         i, bus.out_valid, bus.out_rd, bus.in_ready, (i % 7) + 1);
            end
        end
        drive(0, 3'd0, 16'd0, 16'd0, 16'd0, 0, 3'd0, 0, 0, 1);
        tick();
    endtask

    task automatic test_flush();
        drive(1, 3'd0, 16'd0, 16'd0, 16'hAAAA, 0, 3'd1, 1, 0, 0);
        tick();
        drive(1, 3'd0, 16'd0, 16'd0, 16'hBBBB, 0, 3'd2, 1, 0, 0);
        tick();
        drive(1, 3'd0, 16'd0, 16'd0, 16'hCCCC, 0, 3'd3, 1, 1, 1);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL flush_empty valid=%b in_ready=%b we=%b required 0/1/0",
                     bus.out_valid, bus.in_ready, bus.out_wr_en);
        end
        drive(0, 3'd0, 16'd0, 16'd0, 16'd0, 0, 3'd0, 0, 0, 1);
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== 16'd0) begin
            failures++;
            $display("FAIL flush_dropped valid=%b result=%h required 0/0000", bus.out_valid, bus.out_result);
        end
    endtask

    task automatic test_random();
        ent_t h;
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), a, b,
                  ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom), 1'($urandom),
                  3'($urandom), 1'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
            tick();
            checks++;
            if (bus.out_valid !== (exp_q.size() != 0) || bus.in_ready !== (exp_q.size() != 2)) begin
                failures++;
                $display("FAIL random_hs%0d valid=%b in_ready=%b required %b/%b",
                         i, bus.out_valid, bus.in_ready, exp_q.size() != 0, exp_q.size() != 2);
            end
            h = (exp_q.size() != 0) ? exp_q[0] : '0;
            checks++;
            if ({bus.out_result, bus.out_rd, bus.out_wr_en, bus.out_flags} !== h) begin
                failures++;
                $display("FAIL random_head%0d result=%h rd=%0d we=%b flags=%b required %h/%0d/%b/%b",
                         i, bus.out_result, bus.out_rd, bus.out_wr_en, bus.out_flags,
                         h.result, h.rd, h.wr_en, h.flags);
            end
        end
        drive(0, 3'd0, 16'd0, 16'd0, 16'd0, 0, 3'd0, 0, 1, 1);
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(1, 3'd0, 16'd0, 16'd0, 16'h5555, 0, 3'd5, 1, 0, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_result !== 16'd0) begin
            failures++;
            $display("FAIL reset_async valid=%b in_ready=%b result=%h required 0/1/0000",
                     bus.out_valid, bus.in_ready, bus.out_result);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 3'd1, 16'h0042, 16'h0042, 16'd0, 0, 3'd6, 1, 0, 1);
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h0001 || bus.out_rd !== 3'd6) begin
            failures++;
            $display("FAIL reset_first_push valid=%b result=%h rd=%0d required 1/0001/6",
                     bus.out_valid, bus.out_result, bus.out_rd);
        end
    endtask

    initial begin
        test_reset();
        test_set_ops();
        test_backpressure();
        test_streaming();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
